// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction-fetch front end: PC register, imem req/ack, decode valid/ready
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          COUNT_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        npc,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        pc,
  output logic [31:0]        instr,
  output logic [31:0]        instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               adel,
  output logic [31:0]        fault_pc,
  output logic [COUNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_VALID = 2'd1,
    S_FAULT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        instr_q, instr_d;
  logic               adel_q, adel_d;
  logic [31:0]        fault_pc_q, fault_pc_d;
  logic [COUNT_W-1:0] fetch_count_q, fetch_count_d;

  localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  // Next-state logic: ack only matters in REQ, ready only in VALID; FAULT is terminal until reset
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    adel_d        = adel_q;
    fault_pc_d    = fault_pc_q;
    fetch_count_d = fetch_count_q;
    case (state_q)
      S_REQ: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (instr_ready) begin
          fetch_count_d = fetch_count_q + COUNT_ONE;
          if (npc[1:0] == 2'b00) begin
            pc_d    = npc;
            state_d = S_REQ;
          end else begin
            fault_pc_d = npc;
            adel_d     = 1'b1;
            state_d    = S_FAULT;
          end
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      instr_q       <= 32'h0;
      adel_q        <= 1'b0;
      fault_pc_q    <= 32'h0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      adel_q        <= adel_d;
      fault_pc_q    <= fault_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Handshake outputs come from state only; the request is masked while reset is held
  always_comb begin
    imem_req    = (state_q == S_REQ) && !reset;
    instr_valid = (state_q == S_VALID);
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = pc_q;
  assign adel        = adel_q;
  assign fault_pc    = fault_pc_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed scoreboard testbench for ifetch_unit
module tb_ifetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] npc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        adel;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_pc;
  logic [31:0] exp_count;
  logic [63:0] sb_q[$];

  ifetch_unit #(.RESET_PC(32'h0000_3000), .COUNT_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .npc         (npc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .pc          (pc),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .adel        (adel),
    .fault_pc    (fault_pc),
    .fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory side: hold ack low for 'waits' cycles, then return 'data' and record it
  task automatic fetch(input int waits, input logic [31:0] data);
    for (int i = 0; i < waits; i++) begin
      chk("req_wait", {31'd0, imem_req}, 32'd1);
      chk("addr_wait", imem_addr, exp_pc);
      tick();
    end
    chk("req", {31'd0, imem_req}, 32'd1);
    chk("addr", imem_addr, exp_pc);
    chk("valid_in_req", {31'd0, instr_valid}, 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = data;
    sb_q.push_back({data, exp_pc});
    tick();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    chk("valid_after_ack", {31'd0, instr_valid}, 32'd1);
    chk("req_after_ack", {31'd0, imem_req}, 32'd0);
  endtask

  // Decode side: stall 'stalls' cycles, then handshake with npc_v
  task automatic deliver(input int stalls, input logic [31:0] npc_v);
    logic [63:0] e;
    logic [31:0] old_pc;
    int          guard;
    guard = 0;
    while (!instr_valid && guard < 20) begin
      tick();
      guard++;
    end
    chk("valid_wait_timeout", {31'd0, instr_valid}, 32'd1);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      e = '0;
    end else begin
      e = sb_q.pop_front();
    end
    old_pc = exp_pc;
    for (int i = 0; i < stalls; i++) begin
      chk("stall_instr", instr, e[63:32]);
      chk("stall_instr_pc", instr_pc, e[31:0]);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      instr_ready = 1'b0;
      npc         = 32'h0000_0001;
      tick();
    end
    chk("hs_instr", instr, e[63:32]);
    chk("hs_instr_pc", instr_pc, e[31:0]);
    instr_ready = 1'b1;
    npc         = npc_v;
    tick();
    instr_ready = 1'b0;
    npc         = 32'h0000_0003;
    exp_count   = exp_count + 32'd1;
    chk("count", fetch_count, exp_count);
    chk("valid_after_hs", {31'd0, instr_valid}, 32'd0);
    if (npc_v[1:0] == 2'b00) begin
      exp_pc = npc_v;
      chk("req_after_hs", {31'd0, imem_req}, 32'd1);
      chk("addr_after_hs", imem_addr, exp_pc);
    end else begin
      chk("adel", {31'd0, adel}, 32'd1);
      chk("fault_pc", fault_pc, npc_v);
      chk("pc_hold_fault", pc, old_pc);
      chk("req_fault", {31'd0, imem_req}, 32'd0);
    end
  endtask

  task automatic reset_checks();
    exp_pc    = 32'h0000_3000;
    exp_count = 32'd0;
    chk("rst_pc", pc, 32'h0000_3000);
    chk("rst_instr", instr, 32'h0);
    chk("rst_adel", {31'd0, adel}, 32'd0);
    chk("rst_fault_pc", fault_pc, 32'h0);
    chk("rst_count", fetch_count, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_req_held", {31'd0, imem_req}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rel_req", {31'd0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr, 32'h0000_3000);
  endtask

  initial begin
    reset       = 1'b1;
    npc         = 32'h0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    instr_ready = 1'b0;
    tick();
    tick();
    reset_checks();

    // Zero-wait memory, ready decode: sequential fetch at 0x3000, 0x3004
    fetch(0, 32'h2408_0001);
    deliver(0, exp_pc + 32'd4);
    fetch(0, 32'h2409_0002);
    deliver(0, exp_pc + 32'd4);
    chk("pc_seq", pc, 32'h0000_3008);

    // 3 wait cycles, 2 stall cycles, then branch to 0x3040
    fetch(3, 32'h240A_0003);
    deliver(2, 32'h0000_3040);
    chk("count_three", fetch_count, 32'd3);
    chk("pc_branch", pc, 32'h0000_3040);

    // Spurious ack in VALID must not reload instr
    fetch(0, 32'h1111_2222);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    chk("spur_ack_instr", instr, 32'h1111_2222);
    chk("spur_ack_valid", {31'd0, instr_valid}, 32'd1);
    chk("spur_ack_count", fetch_count, exp_count);
    deliver(0, 32'h0000_3044);

    // Ready in REQ must not count or advance
    instr_ready = 1'b1;
    npc         = 32'h0000_5000;
    tick();
    instr_ready = 1'b0;
    chk("spur_rdy_req", {31'd0, imem_req}, 32'd1);
    chk("spur_rdy_addr", imem_addr, 32'h0000_3044);
    chk("spur_rdy_count", fetch_count, exp_count);
    chk("spur_rdy_instr", instr, 32'h1111_2222);

    // jr to misaligned target -> sticky fault
    fetch(0, 32'h0100_0008);
    deliver(0, 32'h0000_3042);
    for (int i = 0; i < 10; i++) begin
      imem_ack    = 1'b1;
      instr_ready = 1'b1;
      tick();
      chk("fault_req", {31'd0, imem_req}, 32'd0);
      chk("fault_valid", {31'd0, instr_valid}, 32'd0);
      chk("fault_adel", {31'd0, adel}, 32'd1);
    end
    imem_ack    = 1'b0;
    instr_ready = 1'b0;
    chk("fault_count", fetch_count, exp_count);
    chk("fault_pc_hold", pc, 32'h0000_3044);

    // Reset in FAULT clears it and fetching resumes at RESET_PC
    reset = 1'b1;
    tick();
    reset_checks();

    // Reset in REQ with a coincident ack: instr not loaded, no VALID
    fetch(0, 32'h3333_4444);
    deliver(0, exp_pc + 32'd4);
    chk("pre_rst_instr", instr, 32'h3333_4444);
    reset      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'h5555_6666;
    tick();
    imem_ack = 1'b0;
    chk("rst_ack_valid", {31'd0, instr_valid}, 32'd0);
    reset_checks();

    // Reset in VALID drops the undelivered word
    fetch(0, 32'h7777_8888);
    reset = 1'b1;
    tick();
    void'(sb_q.pop_back());
    chk("rst_valid_drop", {31'd0, instr_valid}, 32'd0);
    reset_checks();

    fetch(1, 32'h2408_0009);
    deliver(1, exp_pc + 32'd4);
    chk("final_pc", pc, 32'h0000_3004);
    chk("final_count", fetch_count, 32'd1);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
